// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, debugger hold, END-opcode drain tracking
// and a saturating count of instructions issued to EX.
module id_ex_stage #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicio,
  input  logic              hold_e,
  input  logic              flush_e,
  input  logic              validD,
  input  logic [3:0]        ALUControlID,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic [3:0]        MemWriteD,
  input  logic [1:0]        ALUSrcD,
  input  logic              RegDstD,
  input  logic [1:0]        MemReadD,
  input  logic              finalD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] SignImmD,
  input  logic [DATA_W-1:0] PCPlus4D,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RdD,
  output logic [3:0]        ALUControlE,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic [3:0]        MemWriteE,
  output logic [1:0]        ALUSrcE,
  output logic              RegDstE,
  output logic [1:0]        MemReadE,
  output logic              finalE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] SignImmE,
  output logic [DATA_W-1:0] PCPlus4E,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        RdE,
  output logic              validE,
  output logic              draining,
  output logic              halted,
  output logic [CNT_W-1:0]  issued_cnt
);

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned WORD_W = CTRL_W + 4 * DATA_W + 15;
  localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t              state_q, state_d;
  logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic                draining_q, draining_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [WORD_W-1:0]   d_word;
  logic                adv;
  logic                load;

  assign d_word = {ALUControlID, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, MemReadD,
                   finalD, RD1D, RD2D, SignImmD, PCPlus4D, RsD, RtD, RdD};

  // Next-state: inicio clears unconditionally; otherwise only advancing edges change anything.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    word_d      = word_q;
    valid_d     = valid_q;
    issued_d    = issued_q;
    adv         = !hold_e && (state_q != S_HALTED);
    load        = (state_q == S_RUN) && !flush_e && validD;
    if (inicio) begin
      state_d     = S_RUN;
      drain_cnt_d = '0;
      word_d      = '0;
      valid_d     = 1'b0;
      issued_d    = '0;
    end else if (adv) begin
      if (load) begin
        word_d  = d_word;
        valid_d = 1'b1;
        if (issued_q != {CNT_W{1'b1}}) issued_d = issued_q + CNT_W'(1);
      end else begin
        word_d  = '0;
        valid_d = 1'b0;
      end
      case (state_q)
        S_RUN: begin
          if (load && finalD) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DCNT_W'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) state_d = S_HALTED;
          else drain_cnt_d = drain_cnt_q - DCNT_W'(1);
        end
        default: state_d = state_q;
      endcase
    end
    draining_d = (state_d == S_DRAIN);
    halted_d   = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      drain_cnt_q <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      draining_q  <= 1'b0;
      halted_q    <= 1'b0;
      issued_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      draining_q  <= draining_d;
      halted_q    <= halted_d;
      issued_q    <= issued_d;
    end
  end

  assign {ALUControlE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, MemReadE,
          finalE, RD1E, RD2E, SignImmE, PCPlus4E, RsE, RtE, RdE} = word_q;
  assign validE     = valid_q;
  assign draining   = draining_q;
  assign halted     = halted_q;
  assign issued_cnt = issued_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + randomized bench for id_ex_stage against a behavioural pipeline model;
// a second instance with a 4-bit counter exercises issued_cnt saturation.
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DC     = 3;
  localparam int unsigned W      = 159;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, inicio, hold_e, flush_e, validD;
  logic [3:0] ALUControlID, MemWriteD;
  logic RegWriteD, MemtoRegD, RegDstD, finalD;
  logic [1:0] ALUSrcD, MemReadD;
  logic [31:0] RD1D, RD2D, SignImmD, PCPlus4D;
  logic [4:0] RsD, RtD, RdD;

  wire [W-1:0] e_m, e_s;
  wire v_m, dr_m, h_m, v_s, dr_s, h_s;
  wire [15:0] cnt_m;
  wire [3:0]  cnt_s;

  id_ex_stage #(.DATA_W(DATA_W), .DRAIN_CYCLES(DC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .hold_e(hold_e), .flush_e(flush_e),
    .validD(validD), .ALUControlID(ALUControlID), .RegWriteD(RegWriteD),
    .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .MemReadD(MemReadD), .finalD(finalD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .PCPlus4D(PCPlus4D), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .ALUControlE(e_m[158:155]), .RegWriteE(e_m[154]), .MemtoRegE(e_m[153]),
    .MemWriteE(e_m[152:149]), .ALUSrcE(e_m[148:147]), .RegDstE(e_m[146]),
    .MemReadE(e_m[145:144]), .finalE(e_m[143]), .RD1E(e_m[142:111]), .RD2E(e_m[110:79]),
    .SignImmE(e_m[78:47]), .PCPlus4E(e_m[46:15]), .RsE(e_m[14:10]), .RtE(e_m[9:5]),
    .RdE(e_m[4:0]), .validE(v_m), .draining(dr_m), .halted(h_m), .issued_cnt(cnt_m)
  );

  id_ex_stage #(.DATA_W(DATA_W), .DRAIN_CYCLES(DC), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .inicio(inicio), .hold_e(hold_e), .flush_e(flush_e),
    .validD(validD), .ALUControlID(ALUControlID), .RegWriteD(RegWriteD),
    .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .MemReadD(MemReadD), .finalD(finalD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .PCPlus4D(PCPlus4D), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .ALUControlE(e_s[158:155]), .RegWriteE(e_s[154]), .MemtoRegE(e_s[153]),
    .MemWriteE(e_s[152:149]), .ALUSrcE(e_s[148:147]), .RegDstE(e_s[146]),
    .MemReadE(e_s[145:144]), .finalE(e_s[143]), .RD1E(e_s[142:111]), .RD2E(e_s[110:79]),
    .SignImmE(e_s[78:47]), .PCPlus4E(e_s[46:15]), .RsE(e_s[14:10]), .RtE(e_s[9:5]),
    .RdE(e_s[4:0]), .validE(v_s), .draining(dr_s), .halted(h_s), .issued_cnt(cnt_s)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: mode 0 = running, 1 = draining, 2 = halted
  logic [W-1:0] m_e;
  logic m_v;
  int m_mode, m_left, m_cnt;

  function automatic logic [W-1:0] d_vec();
    return {ALUControlID, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, MemReadD,
            finalD, RD1D, RD2D, SignImmD, PCPlus4D, RsD, RtD, RdD};
  endfunction

  task automatic model_clear();
    m_e = '0; m_v = 1'b0; m_mode = 0; m_left = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic cap;
    if (inicio) model_clear();
    else if (!hold_e && m_mode != 2) begin
      cap = (m_mode == 0) && validD && !flush_e;
      if (cap) begin
        m_e = d_vec(); m_v = 1'b1; m_cnt = m_cnt + 1;
      end else begin
        m_e = '0; m_v = 1'b0;
      end
      if (m_mode == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 2;
      end else if (cap && finalD) begin
        m_mode = 1; m_left = DC;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] c16;
    logic [3:0]  c4;
    c16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    c4  = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
    chk({tag, "_e"}, 256'(e_m), 256'(m_e));
    chk({tag, "_valid"}, 256'(v_m), 256'(m_v));
    chk({tag, "_draining"}, 256'(dr_m), 256'(m_mode == 1));
    chk({tag, "_halted"}, 256'(h_m), 256'(m_mode == 2));
    chk({tag, "_cnt"}, 256'(cnt_m), 256'(c16));
    chk({tag, "_e_s"}, 256'(e_s), 256'(m_e));
    chk({tag, "_flags_s"}, 256'({v_s, dr_s, h_s}), 256'({m_v, m_mode == 1, m_mode == 2}));
    chk({tag, "_cnt_s"}, 256'(cnt_s), 256'(c4));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_word();
    ALUControlID = 4'($urandom); RegWriteD = 1'($urandom); MemtoRegD = 1'($urandom);
    MemWriteD = 4'($urandom); ALUSrcD = 2'($urandom); RegDstD = 1'($urandom);
    MemReadD = 2'($urandom); finalD = 1'b0;
    RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom; PCPlus4D = $urandom;
    RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
  endtask

  task automatic add_word();
    rand_word();
    ALUControlID = 4'b0000; RegWriteD = 1'b1; RegDstD = 1'b1; MemtoRegD = 1'b0;
    MemWriteD = 4'b0000; MemReadD = 2'b00; ALUSrcD = 2'b00;
    RD1D = 32'h10; RD2D = 32'h20;
  endtask

  task automatic end_then_adds(input int hold_at);
    add_word(); finalD = 1'b1; validD = 1'b1;
    tick("end_cap");
    chk("finalE_set", 256'(e_m[143]), 256'(1));
    for (int i = 0; i < 3 + (hold_at >= 0 ? 2 : 0); i++) begin
      add_word(); validD = 1'b1;
      hold_e = (hold_at >= 0) && (i == hold_at || i == hold_at + 1);
      tick("drain");
    end
    hold_e = 1'b0;
    chk("halted_after_drain", 256'(h_m), 256'(1));
    for (int i = 0; i < 10; i++) begin
      add_word(); validD = 1'($urandom);
      tick("halted_hold");
    end
  endtask

  initial begin
    reset = 1'b0; inicio = 1'b0; hold_e = 1'b0; flush_e = 1'b0; validD = 1'b0;
    rand_word();
    model_clear();
    #12;
    check_all("reset");
    reset = 1'b1;

    // Stream of five ADD words
    for (int i = 0; i < 5; i++) begin
      add_word(); validD = 1'b1;
      tick("add_stream");
    end
    chk("cnt_after_5", 256'(cnt_m), 256'(5));

    // Flushed LW, then a normal word
    rand_word(); MemtoRegD = 1'b1; MemReadD = 2'b00; ALUSrcD = 2'b01; validD = 1'b1;
    flush_e = 1'b1;
    tick("flush_lw");
    flush_e = 1'b0;
    add_word();
    tick("after_flush");

    // SW in EX, then a 4-cycle hold with flush and toggling validD
    rand_word(); MemWriteD = 4'b1111; validD = 1'b1;
    tick("sw_load");
    for (int i = 0; i < 4; i++) begin
      hold_e = 1'b1; flush_e = 1'b1; validD = 1'(i); rand_word();
      tick("hold_sw");
      chk("hold_memwrite", 256'(e_m[152:149]), 256'(4'b1111));
    end
    hold_e = 1'b0; flush_e = 1'b0;

    // Random traffic, enough to saturate the 4-bit counter
    for (int i = 0; i < 24; i++) begin
      rand_word(); validD = ($urandom_range(0, 3) != 0); flush_e = ($urandom_range(0, 4) == 0);
      tick("rand_run");
    end
    flush_e = 1'b0;

    // END drain, halt, inicio restart
    end_then_adds(-1);
    add_word(); validD = 1'b1; inicio = 1'b1;
    tick("inicio_clear");
    inicio = 1'b0;
    add_word(); validD = 1'b1;
    tick("post_inicio");

    // END drain with a 2-cycle hold inside DRAIN
    end_then_adds(0);
    inicio = 1'b1;
    tick("inicio_clear2");
    inicio = 1'b0;

    // Random mix of hold/flush/valid/END/inicio
    for (int i = 0; i < 60; i++) begin
      rand_word();
      validD  = ($urandom_range(0, 3) != 0);
      flush_e = ($urandom_range(0, 5) == 0);
      hold_e  = ($urandom_range(0, 5) == 0);
      finalD  = ($urandom_range(0, 11) == 0);
      inicio  = ($urandom_range(0, 24) == 0);
      tick("rand_mix");
    end
    hold_e = 1'b0; flush_e = 1'b0; finalD = 1'b0; inicio = 1'b0;

    // Async reset between edges mid-stream
    for (int i = 0; i < 3; i++) begin
      add_word(); validD = 1'b1;
      tick("pre_areset");
    end
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_all("async_reset");
    @(posedge clk);
    #1 check_all("reset_held");
    reset = 1'b1;
    add_word(); validD = 1'b1;
    tick("after_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the decode stage (control unit, register file, sign extender) and the execute stage.
- Each advancing clock edge it captures the decode-stage control word and operands. It inserts bubbles on hazard flush and freezes under debugger hold.
- It tracks the END opcode (finalD) through the remaining stages and asserts halted once the pipeline has drained.
- It also keeps a count of valid instructions issued to EX, for the debugger.

Parameters:
- DATA_W, 32, operand, immediate and PC width.
- DRAIN_CYCLES, 3, advancing edges after END enters EX before halted rises.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inicio  in  1  synchronous clear; same effect as reset, takes effect at the next edge.
- hold_e  in  1  debugger freeze: register holds its contents, no advance.
- flush_e  in  1  hazard-unit flush: load an EX bubble.
- validD  in  1  decode stage holds a real instruction.
- ALUControlID  in  4  ALU operation code.
- RegWriteD  in  1  register-file write enable.
- MemtoRegD  in  1  writeback selects memory data.
- MemWriteD  in  4  byte-lane write mask.
- ALUSrcD  in  2  ALU operand-source select.
- RegDstD  in  1  destination is rd rather than rt.
- MemReadD  in  2  load width select.
- finalD  in  1  END opcode decoded.
- RD1D, RD2D, SignImmD, PCPlus4D  in  DATA_W each  operands, immediate, PC+4.
- RsD, RtD, RdD  in  5 each  register specifiers.
- ALUControlE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, MemReadE, finalE  out  widths as above  registered control word.
- RD1E, RD2E, SignImmE, PCPlus4E, RsE, RtE, RdE  out  widths as above  registered data.
- validE  out  1  EX holds a real instruction.
- draining  out  1  END captured, pipeline draining.
- halted  out  1  drain complete.
- issued_cnt  out  CNT_W  valid instructions loaded into EX.

Behaviour:
- Reset (reset=0, async) and inicio=1 at an edge:
  - All outputs 0, state RUN, drain counter 0, issued_cnt 0.
  - A bubble is all E outputs = 0, including data fields and validE.
- Advance condition: adv = !hold_e && state != HALTED.
  - With adv=0, every register, the state and issued_cnt hold.
- Load priority on an advancing edge (highest first):
  1. State DRAIN: load a bubble; younger instructions are squashed.
  2. flush_e=1: load a bubble.
  3. validD=0: load a bubble.
  4. Otherwise: load all D inputs, set validE=1, and issued_cnt += 1, saturating at all-ones.
- State machine (states RUN, DRAIN, HALTED):
  - RUN -> DRAIN on an advancing edge that loads an instruction with finalD=1. Then finalE=1, validE=1, drain counter = DRAIN_CYCLES-1.
  - An END blocked by flush_e or validD=0 is not captured and causes no transition.
  - DRAIN: each advancing edge decrements the counter. The edge at which the counter equals 0 moves to HALTED.
  - With the default, halted rises on the 3rd advancing edge after the END capture edge.
  - HALTED: outputs hold the bubble, halted=1, no advance. Exit only via reset or inicio.
- Output flags:
  - draining=1 exactly in DRAIN. halted=1 exactly in HALTED. Both are registered; no combinational input-to-output paths.
  - finalE is high for exactly one advance interval, because the next advancing edge loads a bubble.
- hold_e during DRAIN freezes the counter; the drain counts only advancing edges.
- flush_e together with hold_e: hold wins and the flush is lost. The hazard unit re-asserts flush_e while the stall persists.
- inicio mid-DRAIN or in HALTED: clears to RUN at that edge, including issued_cnt.
- Async reset deassertion: registers start capturing at the first rising edge after reset goes high.

Test Plan:
- Reset, then a stream of 5 valid ADD words (ALUControlID=0000, RegWriteD=1, RegDstD=1, RD1D=0x10, RD2D=0x20), one per cycle -> each appears on E outputs 1 cycle later; validE=1; issued_cnt=5.
- flush_e pulsed for 1 cycle mid-stream with an LW word (MemtoRegD=1, MemReadD=0, ALUSrcD=1) -> that edge gives all E outputs 0; issued_cnt not incremented; the next word passes normally.
- hold_e held 4 cycles while E holds SW (MemWriteD=1111) with flush_e=1 and validD toggling -> MemWriteE stays 1111 and issued_cnt is unchanged for all 4 cycles.
- END (finalD=1) followed by 3 valid ADDs:
  - finalE=1 for 1 cycle, draining=1 on the next cycle, and the ADDs never reach E.
  - halted=1 after the 3rd advancing edge, then stays high for 10 further cycles with E bubbled.
  - Repeat with hold_e=1 for 2 cycles inside DRAIN -> halted is delayed by exactly 2 cycles.
- In HALTED, drive inicio=1 for 1 cycle -> state RUN, halted=0, issued_cnt=0, and the next valid word is captured.
- Async reset asserted between clock edges mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
- Force issued_cnt near 0xFFFF with CNT_W=16 and issue 3 more instructions -> the count saturates at 0xFFFF.
